uart_mem_bridge: RTL

CPU-side initiator for the UART memory protocol. It turns one native memory request (valid/ready, 32-bit address, data and write strobe) into a command byte sequence on a byte stream to the UART core. It then collects the host responder's reply and completes the request. It sits between the RISC-V core's memory port and the `uart` instance's AXI-stream byte ports; the parent drives `prescale`.

---
 rtl/uart_mem_pkg.sv | 17 +
 rtl/uart_mem_bridge.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_mem_pkg.sv
// Shared constants and types for the UART memory protocol.
// Used by the CPU-side bridge and by the bench-side responder.
package uart_mem_pkg;

    localparam logic [7:0]  CmdRead     = 8'h77;
    localparam logic [3:0]  CmdWriteHi  = 4'h2;
    localparam logic [7:0]  WriteAck    = 8'hC8;
    localparam logic [31:0] TimeoutData = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV,
        DONE
    } state_e;

endpackage

// File: rtl/uart_mem_bridge.sv
// CPU memory request -> UART byte-stream command initiator.
// Ports: clk_i/reset_i, mem_* native request, tx_* to UART TX stream,
//        rx_* from UART RX stream, err_o sticky protocol error.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter logic [31:0] TimeoutCycles = 32'd12_000_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  tx_tdata_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    input  logic [7:0]  rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    output logic        err_o
);

    state_e          state_q;
    logic [8:0][7:0] frame_q;
    logic [3:0]      idx_q;
    logic [3:0]      tx_last_q;
    logic [2:0]      rx_left_q;
    logic            wr_q;
    logic [31:0]     rdata_q;
    logic [31:0]     tmo_q;
    logic            ready_q;
    logic            err_q;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;

    logic [8:0][7:0] frame_d;
    logic [3:0]      idx_d;
    logic            is_wr;
    logic            tx_hs;
    logic            tmo_hit;

    assign is_wr   = |mem_wstrb_i;
    assign tx_hs   = tx_valid_q & tx_tready_i;
    assign idx_d   = idx_q + 4'd1;
    assign frame_d = {mem_wdata_i, mem_addr_i,
                      is_wr ? {CmdWriteHi, mem_wstrb_i} : CmdRead};

    // Fires one cycle early: the DONE cycle itself is the last waited
    // cycle, so mem_ready_o rises TimeoutCycles after the clearing event.
    assign tmo_hit = (TimeoutCycles != 32'd0) &&
                     (({1'b0, tmo_q} + 33'd2) >= {1'b0, TimeoutCycles});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            tx_last_q  <= '0;
            rx_left_q  <= '0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            // Only RECV consumes rx bytes; anything else is stray.
            if (rx_tvalid_i && state_q != RECV) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (mem_valid_i) begin
                        frame_q    <= frame_d;
                        wr_q       <= is_wr;
                        tx_last_q  <= is_wr ? 4'd8 : 4'd4;
                        rx_left_q  <= is_wr ? 3'd1 : 3'd4;
                        idx_q      <= '0;
                        rdata_q    <= '0;
                        tmo_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= frame_d[0];
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_hs) begin
                        if (idx_q == tx_last_q) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            tmo_q      <= '0;
                            state_q    <= RECV;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= frame_q[idx_d];
                        end
                    end
                end
                RECV: begin
                    // An rx byte beats a coincident timeout.
                    if (rx_tvalid_i) begin
                        tmo_q     <= '0;
                        rdata_q   <= {rx_tdata_i, rdata_q[31:8]};
                        rx_left_q <= rx_left_q - 3'd1;
                        if (wr_q && rx_tdata_i != WriteAck) begin
                            err_q <= 1'b1;
                        end
                        if (rx_left_q == 3'd1) begin
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (tmo_hit) begin
                        rdata_q <= TimeoutData;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign tx_tdata_o  = tx_data_q;
    assign tx_tvalid_o = tx_valid_q;
    assign rx_tready_o = 1'b1;
    assign err_o       = err_q;

endmodule
